// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic HALF_LO    = 1'b0;
    localparam logic HALF_HI    = 1'b1;
    localparam int   WAIT_CNT_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait timer: reloads at phase entry, counts down to a terminal count.
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last,
    output logic last_next
);

    localparam logic [WAIT_CNT_W-1:0] LOAD_VAL = WAIT_CNT_W'(WAIT_CYCLES - 1);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

    // Lets the owner register strobes that must change on the same edge the count does.
    always_comb begin
        if (load)
            last_next = (LOAD_VAL == '0);
        else if (dec && count != '0)
            last_next = (count == WAIT_CNT_W'(1));
        else
            last_next = (count == '0);
    end

endmodule

// File: rtl/sram_ctrl.sv
// Word-to-half-word bridge from the MEM stage to an external 16-bit async SRAM.
// Optional one-entry read hit buffer: define SRAM_CTRL_READ_HIT_BUF_EN.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 3,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    state_t state, state_d;

    logic [SRAM_AW-2:0] word_q, cur_word, req_word;
    logic               wr_q, cur_wr;
    logic [31:0]        data_q, cur_data;
    logic               req, hit;
    logic               cnt_load, cnt_dec, last, last_next;

    logic [SRAM_AW-1:0] addr_d;
    logic [15:0]        dq_o_d;
    logic               oe_d, we_n_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:SRAM_AW+1], address[1:0]};

    assign req      = mem_read | mem_write;
    assign req_word = address[SRAM_AW:2];
    assign ready    = (state == DONE);
    assign freeze   = req & ~ready;

`ifdef SRAM_CTRL_READ_HIT_BUF_EN
    logic               hit_valid;
    logic [SRAM_AW-2:0] hit_word;
    logic [31:0]        hit_data;

    assign hit = mem_read & ~mem_write & hit_valid & (hit_word == req_word);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_valid <= 1'b0;
            hit_word  <= '0;
            hit_data  <= '0;
        end else begin
            if (state == ACC_HI && last && !wr_q) begin
                hit_valid <= 1'b1;
                hit_word  <= word_q;
                hit_data  <= {sram_dq_i, read_data[15:0]};
            end
            // Keep the entry coherent; the store still goes out to SRAM.
            if (state == IDLE && mem_write && hit_valid && hit_word == req_word)
                hit_data <= data;
        end
    end
`else
    assign hit = 1'b0;
`endif

    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk       (clk),
        .rst       (rst),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .last      (last),
        .last_next (last_next)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (req) state_d = hit ? DONE : ACC_LO;
            ACC_LO:  if (last) state_d = ACC_HI;
            ACC_HI:  if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_load = (state_d == ACC_LO || state_d == ACC_HI) && (state_d != state);
        cnt_dec  = (state == ACC_LO || state == ACC_HI) && !cnt_load;

        cur_word = (state == IDLE) ? req_word  : word_q;
        cur_wr   = (state == IDLE) ? mem_write : wr_q;
        cur_data = (state == IDLE) ? data      : data_q;

        // Pad outputs are registered from the upcoming state so they change cleanly at edges.
        addr_d = sram_addr;
        dq_o_d = sram_dq_o;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (state_d == ACC_LO || state_d == ACC_HI) begin
            addr_d = {cur_word, (state_d == ACC_HI) ? HALF_HI : HALF_LO};
            if (cur_wr) begin
                dq_o_d = (state_d == ACC_HI) ? cur_data[31:16] : cur_data[15:0];
                oe_d   = 1'b1;
                we_n_d = last_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            word_q     <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            read_data  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
        end else begin
            state      <= state_d;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= oe_d;
            sram_we_n  <= we_n_d;
            if (state == IDLE && req) begin
                word_q <= req_word;
                wr_q   <= mem_write;
                data_q <= data;
            end
            if (state == ACC_LO && last && !wr_q)
                read_data[15:0] <= sram_dq_i;
            if (state == ACC_HI && last && !wr_q)
                read_data[31:16] <= sram_dq_i;
`ifdef SRAM_CTRL_READ_HIT_BUF_EN
            if (state == IDLE && hit)
                read_data <= hit_data;
`endif
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl (W=3) with a behavioural async SRAM on the pads.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] address = '0, data = '0;
    logic [31:0] read_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n;

    sram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .data       (data),
        .read_data  (read_data),
        .ready      (ready),
        .freeze     (freeze),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Async SRAM: latches on the rising edge of we_n.
    logic [15:0] sram_mem [0:1023];
    logic        model_en = 1'b0;
    assign sram_dq_i = sram_mem[sram_addr[9:0]];
    always @(posedge sram_we_n) if (model_en) sram_mem[sram_addr[9:0]] <= sram_dq_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] t_addr [0:63];
    logic [15:0] t_dq   [0:63];
    logic        t_we   [0:63];
    logic        t_oe   [0:63];
    logic        t_frz  [0:63];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Called in an IDLE cycle; records pad activity per cycle until ready (bounded).
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat, output int rdy_at);
        mem_read  = rd;
        mem_write = wr;
        address   = a;
        data      = d;
        #1;
        lat = 0;
        while (lat < 40) begin
            t_addr[lat] = sram_addr;
            t_dq[lat]   = sram_dq_o;
            t_we[lat]   = sram_we_n;
            t_oe[lat]   = sram_dq_oe;
            t_frz[lat]  = freeze;
            if (ready) break;
            tick();
            lat++;
        end
        rdy_at = cyc;
    endtask

    task automatic idle_req;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
    endtask

    function automatic int count_we_low(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (t_we[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_oe(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (t_oe[i] == 1'b1) c++;
        return c;
    endfunction

    int lat, r1, r2;
    logic we_exp [0:7];
    logic [31:0] hit_lat;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        we_exp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SRAM_CTRL_READ_HIT_BUF_EN
        hit_lat = 32'd1;
`else
        hit_lat = 32'd7;
`endif
        tick();
        tick();
        chk("rst_ready",     32'(ready),      32'd0);
        chk("rst_read_data", read_data,       32'd0);
        chk("rst_addr",      32'(sram_addr),  32'd0);
        chk("rst_dq_o",      32'(sram_dq_o),  32'd0);
        chk("rst_oe",        32'(sram_dq_oe), 32'd0);
        chk("rst_we_n",      32'(sram_we_n),  32'd1);
        chk("rst_freeze",    32'(freeze),     32'd0);
        model_en = 1'b1;
        rst = 1'b1;
        tick();

        // 1: write 0x10 = DEADBEEF
        do_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, r1);
        chk("t1_latency", 32'(lat), 32'd7);
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("t1_addr_c%0d", i), 32'(t_addr[i]), (i <= 3) ? 32'h8 : 32'h9);
            chk($sformatf("t1_dq_c%0d", i), 32'(t_dq[i]), (i <= 3) ? 32'hBEEF : 32'hDEAD);
        end
        for (int i = 0; i <= 7; i++) begin
            chk($sformatf("t1_we_n_c%0d", i), 32'(t_we[i]), 32'(we_exp[i]));
            chk($sformatf("t1_freeze_c%0d", i), 32'(t_frz[i]), (i <= 6) ? 32'd1 : 32'd0);
        end
        chk("t1_mem_lo", 32'(sram_mem[8]), 32'hBEEF);
        chk("t1_mem_hi", 32'(sram_mem[9]), 32'hDEAD);
        idle_req();

        // 2: read it back
        do_req(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, r1);
        chk("t2_latency",   32'(lat),                32'd7);
        chk("t2_read_data", read_data,               32'hDEAD_BEEF);
        chk("t2_oe_count",  32'(count_oe(0, 7)),     32'd0);
        chk("t2_we_count",  32'(count_we_low(0, 7)), 32'd0);
        idle_req();

        // 3: read+write together is a write
        do_req(1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, lat, r1);
        chk("t3_latency",   32'(lat),                32'd7);
        chk("t3_we_count",  32'(count_we_low(0, 7)), 32'd4);
        chk("t3_mem_lo",    32'(sram_mem[2]),        32'h5678);
        chk("t3_mem_hi",    32'(sram_mem[3]),        32'h1234);
        chk("t3_read_data", read_data,               32'hDEAD_BEEF);
        idle_req();

        // 4: reset in ACC_HI cycle 2 of a write to 0x40
        mem_write = 1'b1;
        address   = 32'h0000_0040;
        data      = 32'hAAAA_5555;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_pre_addr", 32'(sram_addr), 32'h21);
        chk("t4_pre_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        mem_write = 1'b0;
        tick();
        chk("t4_we_n",  32'(sram_we_n),  32'd1);
        chk("t4_oe",    32'(sram_dq_oe), 32'd0);
        chk("t4_ready", 32'(ready),      32'd0);
        chk("t4_state", 32'(dut.state),  32'(IDLE));
        rst = 1'b1;
        tick();
        chk("t4_idle_ready", 32'(ready), 32'd0);
        do_req(1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, lat, r1);
        chk("t4_latency", 32'(lat),           32'd7);
        chk("t4_mem_lo",  32'(sram_mem[34]),  32'hF00D);
        chk("t4_mem_hi",  32'(sram_mem[35]),  32'h0BAD);
        idle_req();

        // 5: back-to-back reads
        do_req(1'b0, 1'b1, 32'h0000_0020, 32'h2222_1111, lat, r1);
        idle_req();
        do_req(1'b0, 1'b1, 32'h0000_0024, 32'h4444_3333, lat, r1);
        idle_req();
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, r1);
        chk("t5_rd0", read_data, 32'h2222_1111);
        address = 32'h0000_0024;
        tick();
        do_req(1'b1, 1'b0, 32'h0000_0024, 32'h0, lat, r2);
        chk("t5_rd1", read_data, 32'h4444_3333);
        chk("t5_gap", 32'(r2 - r1), 32'd8);
        idle_req();

        // wrap-around: address bit 19 and bits [1:0] are ignored
        do_req(1'b1, 1'b0, 32'h0008_0013, 32'h0, lat, r1);
        chk("wrap_addr", 32'(t_addr[1]), 32'h8);
        chk("wrap_data", read_data,      32'hDEAD_BEEF);
        idle_req();

        // 6: repeated read of 0x30, then write-through and re-read
        do_req(1'b0, 1'b1, 32'h0000_0030, 32'h7777_0F0F, lat, r1);
        idle_req();
        do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, lat, r1);
        chk("t6_first_latency", 32'(lat), 32'd7);
        chk("t6_first_data",    read_data, 32'h7777_0F0F);
        idle_req();
        do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, lat, r1);
        chk("t6_again_latency", 32'(lat), hit_lat);
        chk("t6_again_data",    read_data, 32'h7777_0F0F);
        chk("t6_again_we",      32'(count_we_low(0, lat)), 32'd0);
        idle_req();
        do_req(1'b0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, lat, r1);
        chk("t6_wr_latency", 32'(lat),          32'd7);
        chk("t6_wr_mem_lo",  32'(sram_mem[24]), 32'hF00D);
        idle_req();
        do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, lat, r1);
        chk("t6_hit_latency", 32'(lat), hit_lat);
        chk("t6_hit_data",    read_data, 32'hCAFE_F00D);
        idle_req();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
